// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between I-cache and D-cache line transfers (IDLE/XFER/DONE).
// Optional ARB_ROUND_ROBIN_EN: on simultaneous requests, favour whoever did not own the last line.
module mem_port_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  localparam int BEAT_W    = $clog2(LINE_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_grant,
  output logic                 i_rvalid,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_grant,
  output logic                 d_rvalid,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic [BEAT_W-1:0]    beat,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack
);

  localparam int HI_W = WORD_SIZE - BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t               state_q,   state_d;
  owner_t               owner_q,   owner_d;
  logic                 we_q,      we_d;
  logic [HI_W-1:0]      base_q,    base_d;
  logic [BEAT_W-1:0]    beat_q,    beat_d;
  logic [BEAT_W-1:0]    rbeat_q,   rbeat_d;
  logic                 i_rvalid_q, i_rvalid_d;
  logic                 d_rvalid_q, d_rvalid_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  owner_t               winner;

  // Line offset bits of the request addresses are intentionally dropped.
  logic unused_offset_bits;
  assign unused_offset_bits = &{1'b0, i_addr[BEAT_W-1:0], d_addr[BEAT_W-1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner_q, last_owner_d;

  always_comb begin
    winner = OWN_I;
    if (d_req && (!i_req || (last_owner_q == OWN_I))) begin
      winner = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner_q <= OWN_I;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if ((state_q == IDLE) && (i_req || d_req)) begin
      last_owner_d = winner;
    end
  end
`else
  always_comb begin
    winner = d_req ? OWN_D : OWN_I;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      we_q       <= 1'b0;
      base_q     <= '0;
      beat_q     <= '0;
      rbeat_q    <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      base_q     <= base_d;
      beat_q     <= beat_d;
      rbeat_q    <= rbeat_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    base_d     = base_q;
    beat_d     = beat_q;
    rbeat_d    = rbeat_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d = winner;
          we_d    = (winner == OWN_D) && d_we;
          base_d  = (winner == OWN_D) ? d_addr[WORD_SIZE-1:BEAT_W]
                                      : i_addr[WORD_SIZE-1:BEAT_W];
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (mem_ack) begin
          // Remember which beat returned so 'beat' can report it alongside rvalid
          // while the live beat counter has already moved on.
          rbeat_d = beat_q;
          if (!we_q) begin
            if (owner_q == OWN_D) begin
              d_rvalid_d = 1'b1;
              d_rdata_d  = mem_rdata;
            end else begin
              i_rvalid_d = 1'b1;
              i_rdata_d  = mem_rdata;
            end
          end
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  logic active, xfer;

  always_comb begin
    active    = (state_q != IDLE);
    xfer      = (state_q == XFER);
    i_grant   = active && (owner_q == OWN_I);
    d_grant   = active && (owner_q == OWN_D);
    i_done    = (state_q == DONE) && (owner_q == OWN_I);
    d_done    = (state_q == DONE) && (owner_q == OWN_D);
    mem_read  = xfer && !we_q;
    mem_write = xfer && we_q;
    mem_addr  = xfer ? {base_q, beat_q} : '0;
    mem_wdata = (xfer && we_q) ? d_wdata : '0;
    i_rvalid  = i_rvalid_q;
    d_rvalid  = d_rvalid_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    beat      = (i_rvalid_q || d_rvalid_q) ? rbeat_q : beat_q;
  end

  a_one_grant: assert property (@(posedge clk) disable iff (!reset_n)
    !(i_grant && d_grant));
  a_one_strobe: assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_read && mem_write));
  a_strobe_owned: assert property (@(posedge clk) disable iff (!reset_n)
    (mem_read || mem_write) |-> (i_grant || d_grant));

endmodule
